// File: rtl/ma_stream_arbiter.sv
// Round-robin per-packet arbiter sharing one moving-average engine between NUM_CH streams.
// Results are tagged with their source channel via an ID FIFO. Optional counters: MA_ARB_STATS_EN.
module ma_stream_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 32,
  parameter int ID_DEPTH = 4
) (
  input  logic                       s_aclk,
  input  logic                       s_areset,
  input  logic [NUM_CH-1:0]          s_axis_tvalid,
  input  logic [NUM_CH*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_CH-1:0]          s_axis_tlast,
  output logic [NUM_CH-1:0]          s_axis_tready,
  output logic                       e_axis_tvalid,
  output logic [DATA_W-1:0]          e_axis_tdata,
  output logic                       e_axis_tlast,
  input  logic                       e_axis_tready,
  input  logic                       r_axis_tvalid,
  input  logic [DATA_W-1:0]          r_axis_tdata,
  input  logic                       r_axis_tlast,
  output logic                       r_axis_tready,
  output logic                       m_axis_tvalid,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic [$clog2(NUM_CH)-1:0]  m_axis_tdest,
  input  logic                       m_axis_tready,
  output logic                       err_underflow,
  output logic [NUM_CH*16-1:0]       stat_beats
);

  // state | meaning
  // IDLE  | no owner; next requester is picked round-robin starting at rr_ptr
  // LOCK  | grant owns the engine input until its tlast beat is accepted

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(ID_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   id_mem_q [ID_DEPTH];
  logic [CH_W-1:0]   id_mem_d [ID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  logic              fifo_empty, fifo_full, push, pop;
  logic [CH_W-1:0]   pick, cand;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(ID_DEPTH));

  always_comb begin
    s_axis_tready = '0;
    e_axis_tvalid = 1'b0;
    e_axis_tdata  = '0;
    e_axis_tlast  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_q == CH_W'(k)) begin
        e_axis_tdata = s_axis_tdata[k*DATA_W +: DATA_W];
        e_axis_tlast = s_axis_tlast[k];
        if (state_q == ST_LOCK) begin
          e_axis_tvalid    = s_axis_tvalid[k] & ~fifo_full;
          s_axis_tready[k] = e_axis_tready & ~fifo_full;
        end
      end
    end
  end

  assign push = e_axis_tvalid & e_axis_tready;

  // An empty FIFO means any result is orphaned: swallow it so the engine never stalls on it.
  assign m_axis_tvalid = r_axis_tvalid & ~fifo_empty;
  assign m_axis_tdata  = r_axis_tdata;
  assign m_axis_tlast  = r_axis_tlast;
  assign m_axis_tdest  = id_mem_q[rd_ptr_q];
  assign r_axis_tready = fifo_empty ? r_axis_tvalid : m_axis_tready;
  assign pop           = r_axis_tvalid & m_axis_tready & ~fifo_empty;
  assign err_underflow = err_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    pick     = rr_ptr_q;
    cand     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
      if (s_axis_tvalid[cand]) pick = cand;
    end
    case (state_q)
      ST_IDLE: begin
        if (|s_axis_tvalid) begin
          grant_d = pick;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (push && e_axis_tlast) begin
          rr_ptr_d = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    id_mem_d = id_mem_q;
    if (push) id_mem_d[wr_ptr_q] = grant_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    err_d    = err_q | (r_axis_tvalid & fifo_empty);
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < ID_DEPTH; i++) id_mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      id_mem_q <= id_mem_d;
    end
  end

`ifdef MA_ARB_STATS_EN
  logic [15:0] stat_q [NUM_CH];
  logic [15:0] stat_d [NUM_CH];

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      stat_d[k] = stat_q[k];
      if (push && grant_q == CH_W'(k) && stat_q[k] != 16'hFFFF) stat_d[k] = stat_q[k] + 16'd1;
    end
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      for (int k = 0; k < NUM_CH; k++) stat_q[k] <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_stat
    assign stat_beats[k*16 +: 16] = stat_q[k];
  end
`else
  assign stat_beats = '0;
`endif

endmodule
